// File: rtl/alu_result_checker.sv
// alu_result_checker: scoreboard for an ALU. Predicted results are queued in a
// small FIFO and compared in order against actual results strobed by `done`.
// Matches, mismatches and underflows are counted with saturating counters.
// Optional watchdog compiled in with macro ALU_CHECKER_TIMEOUT_EN; without it
// the timeout output is tied low.
module alu_result_checker #(
    parameter int RESULT_W = 16,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [RESULT_W-1:0]      exp_result,
    input  logic                     done,
    input  logic [RESULT_W-1:0]      result,
    input  logic                     clr,
    output logic [CNT_W-1:0]         pass_count,
    output logic [CNT_W-1:0]         fail_count,
    output logic                     mismatch,
    output logic [RESULT_W-1:0]      last_exp,
    output logic [RESULT_W-1:0]      last_act,
    output logic                     underflow,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Parameter sanity: DEPTH must be a power of two >= 2 so pointers wrap freely.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("alu_result_checker: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    logic [RESULT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic [CNT_W-1:0]    pass_q, fail_q;
    logic [RESULT_W-1:0] last_exp_q, last_act_q;
    logic                mismatch_q, underflow_q;

    logic                push, pop, uflow, match, miss;
    logic [RESULT_W-1:0] head;

    // Handshake and compare decode, all from start-of-cycle (registered) level;
    // a same-cycle push therefore never feeds that cycle's pop.
    assign exp_ready = (level_q < DEPTH_L);
    assign push      = exp_valid && exp_ready;
    assign pop       = done && (level_q != '0);
    assign uflow     = done && (level_q == '0);
    assign head      = mem_q[rd_ptr_q];
    assign match     = pop && (head == result);
    assign miss      = pop && (head != result);

    // Occupancy next state: push and pop together leave it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= exp_result;
    end

    // FIFO pointers and level; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Result bookkeeping; clr wins over any same-cycle update, mismatch pulse excepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_q      <= '0;
            fail_q      <= '0;
            last_exp_q  <= '0;
            last_act_q  <= '0;
            underflow_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            mismatch_q <= miss || uflow;
            if (clr) begin
                pass_q      <= '0;
                fail_q      <= '0;
                last_exp_q  <= '0;
                last_act_q  <= '0;
                underflow_q <= 1'b0;
            end else begin
                if (match && pass_q != CNT_MAX) pass_q <= pass_q + 1'b1;
                if ((miss || uflow) && fail_q != CNT_MAX) fail_q <= fail_q + 1'b1;
                if (miss) begin
                    last_exp_q <= head;
                    last_act_q <= result;
                end else if (uflow) begin
                    last_exp_q  <= '0;
                    last_act_q  <= result;
                    underflow_q <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_CHECKER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    // Watchdog: counts idle cycles with work outstanding, holds at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (clr) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (done || level_q == '0) begin
            wd_q <= '0;
        end else if (wd_q != WD_LIM) begin
            wd_q <= wd_q + 1'b1;
            if (wd_q + 1'b1 == WD_LIM) timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign level      = level_q;
    assign pass_count = pass_q;
    assign fail_count = fail_q;
    assign mismatch   = mismatch_q;
    assign last_exp   = last_exp_q;
    assign last_act   = last_act_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench for alu_result_checker: directed scenarios plus a random
// phase, every cycle compared against a queue-based reference model.
module tb_alu_result_checker;
    localparam int RW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 5;
    localparam int TO    = 10;
    localparam int CMAX  = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           exp_valid, exp_ready, done, clr;
    logic [RW-1:0]  exp_result, result;
    logic [CW-1:0]  pass_count, fail_count;
    logic           mismatch, underflow, timeout;
    logic [RW-1:0]  last_exp, last_act;
    logic [$clog2(DEPTH):0] level;

    alu_result_checker #(.RESULT_W(RW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_result(exp_result), .done(done), .result(result), .clr(clr),
        .pass_count(pass_count), .fail_count(fail_count), .mismatch(mismatch),
        .last_exp(last_exp), .last_act(last_act), .underflow(underflow),
        .timeout(timeout), .level(level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // reference model state
    logic [RW-1:0] mq[$];
    int            m_pass, m_fail, m_wd;
    logic          m_mis, m_uf, m_to;
    logic [RW-1:0] m_le, m_la;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pass = 0; m_fail = 0; m_wd = 0;
        m_mis = 0; m_uf = 0; m_to = 0; m_le = '0; m_la = '0;
    endtask

    task automatic check_all();
        chk("level",     32'(level),      mq.size());
        chk("exp_ready", 32'(exp_ready),  32'(mq.size() < DEPTH));
        chk("pass",      32'(pass_count), m_pass);
        chk("fail",      32'(fail_count), m_fail);
        chk("mismatch",  32'(mismatch),   32'(m_mis));
        chk("last_exp",  32'(last_exp),   32'(m_le));
        chk("last_act",  32'(last_act),   32'(m_la));
        chk("underflow", 32'(underflow),  32'(m_uf));
        chk("timeout",   32'(timeout),    32'(m_to));
    endtask

    // One clock: drive inputs, advance the model by the spec rules, compare.
    task automatic step(input logic v, input logic [RW-1:0] d, input logic dn,
                        input logic [RW-1:0] r, input logic c);
        int lvl;
        logic [RW-1:0] h;
        exp_valid = v; exp_result = d; done = dn; result = r; clr = c;
        lvl = mq.size();
        m_mis = 0;
`ifdef ALU_CHECKER_TIMEOUT_EN
        if (c || dn || lvl == 0) m_wd = 0;
        else if (m_wd < TO) begin
            m_wd++;
            if (m_wd == TO) m_to = 1;
        end
`endif
        if (dn) begin
            if (lvl > 0) begin
                h = mq.pop_front();
                if (h == r) begin
                    if (m_pass < CMAX) m_pass++;
                end else begin
                    if (m_fail < CMAX) m_fail++;
                    m_mis = 1; m_le = h; m_la = r;
                end
            end else begin
                if (m_fail < CMAX) m_fail++;
                m_mis = 1; m_uf = 1; m_le = '0; m_la = r;
            end
        end
        if (v && lvl < DEPTH) mq.push_back(d);
        if (c) begin
            m_pass = 0; m_fail = 0; m_le = '0; m_la = '0; m_uf = 0; m_to = 0;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [RW-1:0] d, r;
        reset_n = 1'b0; exp_valid = 0; exp_result = '0; done = 0; result = '0; clr = 0;
        model_reset();
        #12;
        check_all();
        chk("rst_ready", 32'(exp_ready), 1);
        @(negedge clk) reset_n = 1'b1;

        // three in-order matches
        step(1, 16'h0005, 0, 0, 0);
        step(1, 16'h0006, 0, 0, 0);
        step(1, 16'h0007, 0, 0, 0);
        step(0, 0, 1, 16'h0005, 0);
        step(0, 0, 1, 16'h0006, 0);
        step(0, 0, 1, 16'h0007, 0);
        chk("t037_pass", 32'(pass_count), 3);
        chk("t037_level", 32'(level), 0);

        // single mismatch
        step(1, 16'h00FF, 0, 0, 0);
        step(0, 0, 1, 16'h00FE, 0);
        chk("t038_mis", 32'(mismatch), 1);
        chk("t038_lexp", 32'(last_exp), 32'h00FF);
        chk("t038_lact", 32'(last_act), 32'h00FE);
        idle();
        chk("t038_mis_drop", 32'(mismatch), 0);
        step(0, 0, 0, 0, 1);

        // fill, overfill, then push/pop pairs across the wrap
        for (int i = 0; i < DEPTH; i++) step(1, 16'(16'h0100 + i), 0, 0, 0);
        chk("t039_full_ready", 32'(exp_ready), 0);
        step(1, 16'hDEAD, 0, 0, 0);
        chk("t039_full_level", 32'(level), DEPTH);
        step(0, 0, 1, mq[0], 0);
        for (int i = 0; i < 20; i++) step(1, 16'(16'h0200 + i), 1, mq[0], 0);
        while (mq.size() > 0) step(0, 0, 1, mq[0], 0);
        chk("t039_pass", 32'(pass_count), 28);

        // underflow with a coincident push
        step(1, 16'h0010, 1, 16'h0033, 0);
        chk("t040_uf", 32'(underflow), 1);
        chk("t040_level", 32'(level), 1);
        chk("t040_lexp", 32'(last_exp), 0);
        step(0, 0, 1, 16'h0010, 0);
        chk("t040_head", 32'(pass_count), 29);

        // counter saturation
        step(1, 16'h0A0A, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 16'(16'h0300 + i), 1, mq[0], 0);
        step(0, 0, 1, mq[0], 0);
        chk("sat_pass", 32'(pass_count), CMAX);
        for (int i = 0; i < 35; i++) step(0, 0, 1, 16'(i), 0);
        chk("sat_fail", 32'(fail_count), CMAX);
        step(0, 0, 0, 0, 1);

        // watchdog: one outstanding entry, no done
        step(1, 16'h0077, 0, 0, 0);
        for (int i = 0; i < TO + 1; i++) idle();
`ifdef ALU_CHECKER_TIMEOUT_EN
        chk("t041_timeout", 32'(timeout), 1);
`else
        chk("t041_timeout", 32'(timeout), 0);
`endif
        step(0, 0, 0, 0, 1);
        chk("t041_clr", 32'(timeout), 0);
        step(0, 0, 1, 16'h0077, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            d = 16'($urandom);
            r = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[0] : 16'($urandom);
            step(1'($urandom_range(1)), d, 1'($urandom_range(2) == 0), r,
                 1'($urandom_range(40) == 0));
        end

        // reset mid-run with entries queued
        step(1, 16'h1111, 0, 0, 0);
        step(1, 16'h2222, 0, 0, 0);
        exp_valid = 0; done = 0; clr = 0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_level", 32'(level), 0);
        chk("rst_mid_ready", 32'(exp_ready), 1);
        check_all();
        @(negedge clk) reset_n = 1'b1;
        step(1, 16'h4242, 0, 0, 0);
        chk("rst_first_push", 32'(level), 1);
        step(0, 0, 1, 16'h4242, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        failed++;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 Parameter RESULT_W, default 16, width of expected and actual ALU result.
REQ-002 Parameter DEPTH, default 8, expected-result FIFO entries; power of two, minimum 2.
REQ-003 Parameter CNT_W, default 16, width of pass/fail counters.
REQ-004 Parameter TIMEOUT, default 1000, watchdog cycle limit; used only with ALU_CHECKER_TIMEOUT_EN.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 exp_valid  input  1  predicted result present on exp_result.
REQ-008 exp_ready  output  1  checker can accept a predicted result.
REQ-009 exp_result  input  RESULT_W  predicted ALU result.
REQ-010 done  input  1  ALU completion strobe; one cycle per completed operation.
REQ-011 result  input  RESULT_W  actual ALU result, valid while done=1.
REQ-012 clr  input  1  synchronous clear of counters and sticky flags; FIFO untouched.
REQ-013 pass_count  output  CNT_W  number of matching compares.
REQ-014 fail_count  output  CNT_W  number of mismatches plus underflows.
REQ-015 mismatch  output  1  one-cycle pulse, compare failed.
REQ-016 last_exp, last_act  output  RESULT_W each  operands of most recent failing compare.
REQ-017 underflow  output  1  sticky; done seen with FIFO empty.
REQ-018 timeout  output  1  sticky; watchdog expired.
REQ-019 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-020 Push occurs when exp_valid && exp_ready at rising edge; exp_result written at tail.
REQ-021 exp_ready SHALL be 1 exactly when level < DEPTH, derived from registered level only.
REQ-022 Pop occurs when done=1 and level at start of cycle > 0; head compared with result.
REQ-023 A push in the same cycle is not visible to that cycle's pop; done with level=0 is an underflow even if a push coincides.
REQ-024 Simultaneous push and pop with 0<level<DEPTH: level unchanged, both pointers advance.
REQ-025 Pointers wrap modulo DEPTH with no lost or duplicated entry.
REQ-026 Match: pass_count increments in cycle after done; mismatch stays 0.
REQ-027 Mismatch: fail_count increments, mismatch=1 for exactly the cycle after done, last_exp/last_act load head/result.
REQ-028 Underflow: underflow set, fail_count increments, last_act loads result, last_exp loads 0, mismatch pulses, no pop.
REQ-029 Counters saturate at all-ones; no wrap.
REQ-030 clr: counters, last_exp, last_act, underflow, timeout, watchdog cleared next cycle; clr has priority over a same-cycle increment; FIFO push/pop still occur.

Reset
REQ-031 reset_n=0 asynchronously clears FIFO pointers, level, counters, last_exp, last_act, mismatch, underflow, timeout, watchdog.
REQ-032 After reset exp_ready=1, level=0; reset mid-operation discards all queued expectations.
REQ-033 Removal of reset is synchronous to clk; first push accepted on first edge with reset_n=1.

Configuration
REQ-034 Macro ALU_CHECKER_TIMEOUT_EN compiles in the watchdog.
REQ-035 With macro: counter increments each cycle level>0 and done=0, clears on done or level=0; reaching TIMEOUT sets timeout sticky and counter holds.
REQ-036 Without macro: no watchdog logic; timeout tied to 0.

Verification
REQ-037 Push 0x0005, 0x0006, 0x0007; done with result 0x0005, 0x0006, 0x0007 -> pass_count=3, fail_count=0, level=0.
REQ-038 Push 0x00FF; done with result 0x00FE -> mismatch one cycle, fail_count=1, last_exp=0x00FF, last_act=0x00FE.
REQ-039 Fill 8 entries -> exp_ready=0, 9th push ignored; then 20 push/pop pairs across wrap -> all pass, pass_count=28.
REQ-040 done with level=0 plus coincident push of 0x0010 -> underflow=1, fail_count=1, level=1, head=0x0010.
REQ-041 With ALU_CHECKER_TIMEOUT_EN, TIMEOUT=10, one push, no done -> timeout=1 after 10 cycles; clr -> timeout=0; assert reset_n mid-run -> level=0, exp_ready=1 immediately.
